// File: rtl/adrv9001_tx_pkg.sv
// Shared definitions for the ADRV9001 TX enable sequencer.
// State encoding, data source selects and counter sizes.
package adrv9001_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RF_ON  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_RF_OFF = 2'd3
  } tx_state_t;

  localparam logic [1:0] SRC_STREAM = 2'd0;
  localparam logic [1:0] SRC_CONST  = 2'd1;
  localparam logic [1:0] SRC_ZERO   = 2'd2;

  localparam int UF_WIDTH = 16;
  localparam logic [UF_WIDTH-1:0] UF_MAX = '1;

  function automatic logic is_stream(input logic [1:0] src);
    return src == SRC_STREAM;
  endfunction

endpackage

// File: rtl/adrv9001_tx_delay_cnt.sv
// Sample-rate divider and loadable down-counter that is
// decremented once per sample tick while nonzero.
module adrv9001_tx_delay_cnt #(
  parameter int CNT_WIDTH = 16,
  parameter int CE_DIV    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic                 ce,
  output logic                 zero
);

  localparam int DIV_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);

  logic [DIV_W-1:0]     div_cnt;
  logic [CNT_WIDTH-1:0] cnt;

  assign ce   = (div_cnt == DIV_LAST);
  assign zero = (cnt == '0);

  // Free-running modulo-CE_DIV divider; CE_DIV=1 pins it at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Load has priority; otherwise count down on each sample tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (ce && !zero) begin
      cnt <= cnt - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/adrv9001_tx_enable_ctrl.sv
// ADRV9001 TX channel enable sequencer and transmit data gate.
// Drives the enable pin, the SSI run enable and the word source.
module adrv9001_tx_enable_ctrl
  import adrv9001_tx_pkg::*;
#(
  parameter int CNT_WIDTH  = 16,
  parameter int CE_DIV     = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  enable_mode,
  input  logic [CNT_WIDTH-1:0]  enable_delay,
  input  logic [CNT_WIDTH-1:0]  disable_delay,
  input  logic [1:0]            data_src,
  input  logic [DATA_WIDTH-1:0] const_data,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  adrv9001_enable,
  output logic                  ssi_enable,
  input  logic                  underflow_clr,
  output logic [UF_WIDTH-1:0]   underflow_cnt,
  output logic [1:0]            state
);

  tx_state_t cur_state;
  logic      mode_pin;

  logic                 unused_ce;
  logic                 zero;
  logic                 start_pin;
  logic                 stop_pin;
  logic                 load;
  logic [CNT_WIDTH-1:0] load_val;

  logic                  word_take;
  logic                  starve;
  logic [DATA_WIDTH-1:0] next_word;
  logic [DATA_WIDTH-1:0] data_q;

  assign state = cur_state;

  // Counter is loaded only on entry to the RF_ON / RF_OFF windows
  assign start_pin = (cur_state == ST_IDLE) & enable & enable_mode;
  assign stop_pin  = (cur_state == ST_ACTIVE) & ~enable & mode_pin;
  assign load      = start_pin | stop_pin;
  assign load_val  = start_pin ? enable_delay : disable_delay;

  adrv9001_tx_delay_cnt #(
    .CNT_WIDTH (CNT_WIDTH),
    .CE_DIV    (CE_DIV)
  ) u_delay_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .ce       (unused_ce),
    .zero     (zero)
  );

  // Enable sequencer; the pin tracks the state, SSI lags it a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state       <= ST_IDLE;
      mode_pin        <= 1'b0;
      adrv9001_enable <= 1'b0;
      ssi_enable      <= 1'b0;
    end else begin
      ssi_enable <= (cur_state == ST_ACTIVE) |
                    (cur_state == ST_RF_OFF);
      case (cur_state)
        ST_IDLE: begin
          if (enable) begin
            mode_pin <= enable_mode;
            if (enable_mode) begin
              cur_state       <= ST_RF_ON;
              adrv9001_enable <= 1'b1;
            end else begin
              cur_state       <= ST_ACTIVE;
              adrv9001_enable <= 1'b0;
            end
          end
        end
        ST_RF_ON: begin
          if (!enable) begin
            cur_state       <= ST_IDLE;
            adrv9001_enable <= 1'b0;
          end else if (zero) begin
            cur_state       <= ST_ACTIVE;
            adrv9001_enable <= mode_pin;
          end
        end
        ST_ACTIVE: begin
          if (!enable) begin
            if (mode_pin) begin
              cur_state       <= ST_RF_OFF;
              adrv9001_enable <= 1'b1;
            end else begin
              cur_state       <= ST_IDLE;
              adrv9001_enable <= 1'b0;
            end
          end
        end
        ST_RF_OFF: begin
          if (enable) begin
            cur_state       <= ST_ACTIVE;
            adrv9001_enable <= mode_pin;
          end else if (zero) begin
            cur_state       <= ST_IDLE;
            adrv9001_enable <= 1'b0;
          end
        end
        default: begin
          cur_state       <= ST_IDLE;
          adrv9001_enable <= 1'b0;
        end
      endcase
    end
  end

  assign word_take     = ssi_enable & m_ready;
  assign s_axis_tready = word_take & is_stream(data_src);
  assign starve        = s_axis_tready & ~s_axis_tvalid;

  // Word offered to the unpacker for the selected source
  always_comb begin
    next_word = '0;
    case (data_src)
      SRC_STREAM: next_word = s_axis_tvalid ? s_axis_tdata : '0;
      SRC_CONST:  next_word = const_data;
      default:    next_word = '0;
    endcase
  end

  // Output word register, cleared while the SSI is stopped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (!ssi_enable) begin
      data_q <= '0;
    end else if (m_ready) begin
      data_q <= next_word;
    end
  end

  assign m_data = ssi_enable ? data_q : '0;

  // Saturating underflow counter; clear beats a same-cycle increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow_cnt <= '0;
    end else if (underflow_clr) begin
      underflow_cnt <= '0;
    end else if (starve && underflow_cnt != UF_MAX) begin
      underflow_cnt <= underflow_cnt + UF_WIDTH'(1);
    end
  end

endmodule

// File: doc/adrv9001_tx_enable_ctrl.md
# adrv9001_tx_enable_ctrl

Parametrised enable sequencer and data gate for one ADRV9001 transmit channel. It sits between the user AXI-stream source and the serdes unpacker, in the `dclk_div` domain. It drives the ADRV9001 TX enable pin and the SSI enable, and selects the transmit data source. Compared with the previous channel logic, it adds:
- an explicit state machine with abortable enable/disable windows,
- a configurable sample-rate divider,
- a constant-data test source,
- underflow accounting.

## Interface
Parameters:
- `CNT_WIDTH`, 16: width of the delay inputs and delay counter.
- `CE_DIV`, 2: `clk` cycles per sample; legal range 1..16.
- `DATA_WIDTH`, 32: packed IQ word width.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  `dclk_div` domain clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  transmit request; already synchronised to `clk`.
- `enable_mode`  in  1  0 = SPI mode, 1 = pin mode.
- `enable_delay`  in  CNT_WIDTH  samples from pin assert to SSI enable.
- `disable_delay`  in  CNT_WIDTH  samples from `enable` fall to pin deassert.
- `data_src`  in  2  0 = stream, 1 = `const_data`, 2/3 = zeros.
- `const_data`  in  DATA_WIDTH  test word.
- `s_axis_tdata`  in  DATA_WIDTH  user IQ data.
- `s_axis_tvalid`  in  1  user data valid.
- `s_axis_tready`  out  1  user data accepted.
- `m_ready`  in  1  unpacker ready for a new word (unpacker `din_rdy`).
- `m_data`  out  DATA_WIDTH  word to unpacker.
- `adrv9001_enable`  out  1  ADRV9001 TX enable pin.
- `ssi_enable`  out  1  serdes/unpacker run (unpacker reset = `~ssi_enable`).
- `underflow_clr`  in  1  clears `underflow_cnt`.
- `underflow_cnt`  out  16  saturating count of starved words.
- `state`  out  2  current state encoding, for debug.

## Operation
Sample tick `ce`:
- Free-running modulo-`CE_DIV` counter, reset to 0.
- `ce` is high when the counter equals `CE_DIV-1`; for `CE_DIV`=1 it is always high.

States:
- **IDLE**
  - Outputs: `adrv9001_enable`=0, `ssi_enable`=0, `m_data`=0.
  - On `enable`=1 with `enable_mode`=1: go to RF_ON and load the counter with `enable_delay`.
  - On `enable`=1 with `enable_mode`=0: go to ACTIVE.
  - `enable_mode` is sampled only in IDLE.
- **RF_ON**
  - `adrv9001_enable`=1, `ssi_enable`=0.
  - Counter decrements on `ce` while it is nonzero.
  - Counter == 0: go to ACTIVE.
  - `enable` falls before the count ends: go to IDLE (abort).
- **ACTIVE**
  - `ssi_enable`=1; `adrv9001_enable` = latched mode bit.
  - `enable` falls in pin mode: go to RF_OFF and load the counter with `disable_delay`.
  - `enable` falls in SPI mode: go to IDLE.
- **RF_OFF**
  - `adrv9001_enable`=1, `ssi_enable`=1; data continues to flow.
  - Counter decrements on `ce`.
  - Counter == 0: go to IDLE.
  - `enable` rises before the count ends: go back to ACTIVE (abort), and the counter is not reloaded.

Counter rule: a delay of 0 gives exactly one clock in RF_ON or RF_OFF. A delay of N gives N `ce` ticks plus at most `CE_DIV` clocks.

Data path:
- `s_axis_tready = ssi_enable & m_ready & (data_src==0)`; this is combinational.
- On a clock where `m_ready`=1 and `ssi_enable`=1, `m_data` is loaded from:
  - stream: `s_axis_tdata` if `s_axis_tvalid`, otherwise 0;
  - constant: `const_data`;
  - otherwise: 0.
- With `ssi_enable`=0, `m_data` is 0.
- Underflow: `data_src`==0, `m_ready`=1, `ssi_enable`=1 and `s_axis_tvalid`=0 together increment `underflow_cnt`.
  - The count saturates at 0xFFFF.
  - If `underflow_clr` is high, it wins over an increment in the same cycle.

Reset: every output is 0, `state` is IDLE, and the `ce` counter is 0. Reset asserted mid-sequence forces IDLE immediately; the pin drops asynchronously.

## Timing
- State changes take effect at the clock edge after the qualifying condition; `adrv9001_enable` and `ssi_enable` are registered decodes of the state.
- `m_data` latency is one clock from the `s_axis_tready`/`s_axis_tvalid` handshake.
- The `data_src` change takes effect on the next loaded word.
- `enable_delay` and `disable_delay` are sampled only at counter load.

## Structure
- Package `adrv9001_tx_pkg` holds:
  - the state encoding (IDLE=0, RF_ON=1, ACTIVE=2, RF_OFF=3);
  - the `data_src` encodings;
  - the underflow counter width (16).
- Sub-module `adrv9001_tx_delay_cnt` owns the `ce` divider and the loadable, `ce`-gated down-counter, with outputs `ce` and `zero`.

## Test plan
- **Pin mode sequence:** `CE_DIV`=2, `enable_delay`=3, `disable_delay`=2, `enable` pulse of 40 clocks. Expected:
  - the pin rises 1 clock after `enable`;
  - `ssi_enable` rises 6–8 clocks after the pin;
  - the pin falls 4–6 clocks after `enable` falls.
- **SPI mode:** `enable_mode`=0. Expected: the pin stays 0, and `ssi_enable` follows `enable` with 2 clocks of latency.
- **Abort windows:**
  - `enable` drops during RF_ON → IDLE next clock, `ssi_enable` never rises.
  - `enable` re-rises during RF_OFF → ACTIVE, pin never drops.
- **Underflow:** stream mode, `m_ready`=1, `s_axis_tvalid` low for 5 ready cycles. Expected:
  - `underflow_cnt`=5 and `m_data`=0 on those words;
  - `underflow_clr` returns the count to 0;
  - preloading the count to 0xFFFF and starving once leaves it saturated at 0xFFFF.
- **Constant source:** `data_src`=1, `const_data`=0x7FFF8000. Expected: every loaded `m_data` is 0x7FFF8000 and `s_axis_tready` stays 0.
- **Reset mid-RF_OFF:** `rst` asserted in RF_OFF. Expected: all outputs 0 and `state`=IDLE without waiting for a clock edge.
